// File: rtl/serial_port.sv
// 8051 serial port datapath (modes 1 and 3): transmits SBUF writes on txd, receives rxd
// into the receive buffer, and returns one-cycle TI/RI/RB8 update pulses to the SFR block.
module serial_port #(
    parameter int SYNC_STAGES = 2,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scon,
    input  logic       smod,
    input  logic       t1_ovf,
    input  logic       sbuf_wr,
    input  logic [7:0] sbuf_wdata,
    input  logic       rxd,
    output logic       txd,
    output logic [7:0] rx_data,
    output logic       rb8_set,
    output logic       rb8_val,
    output logic       ti_set,
    output logic       ri_set,
    output logic       tx_busy,
    output logic       rx_busy
);
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_NINTH, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_NINTH, RX_STOP} rx_state_t;

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

    logic mode_ok, sm0, sm2, ren, tb8, ri;
    assign sm0     = scon[7];
    assign mode_ok = scon[6];   // SM1=1 selects mode 1 or 3
    assign sm2     = scon[5];
    assign ren     = scon[4];
    assign tb8     = scon[3];
    assign ri      = scon[0];

    logic unused_scon;
    assign unused_scon = ^scon[2:1];

    logic presc, tick;
    assign tick = t1_ovf & (smod | presc);

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      presc <= 1'b0;
        else if (t1_ovf) presc <= ~presc;
    end

    // ---------------- transmitter ----------------
    tx_state_t  tx_state, tx_state_d;
    logic [3:0] tx_cnt, tx_cnt_d;
    logic [2:0] tx_bit, tx_bit_d;
    logic [7:0] tx_shift, tx_shift_d;
    logic       tx_nine, tx_nine_d, tx_m3, tx_m3_d, txd_d, tx_bit_end;

    assign tx_bit_end = tick && (tx_cnt == LAST_TICK);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt;
        tx_bit_d   = tx_bit;
        tx_shift_d = tx_shift;
        tx_nine_d  = tx_nine;
        tx_m3_d    = tx_m3;
        if (tick && tx_state != TX_IDLE && tx_state != TX_WAIT) tx_cnt_d = tx_cnt + 4'd1;
        case (tx_state)
            TX_IDLE: if (sbuf_wr && mode_ok) begin
                tx_shift_d = sbuf_wdata;
                tx_nine_d  = tb8;
                tx_m3_d    = sm0;
                tx_state_d = TX_WAIT;
            end
            TX_WAIT: if (tick) begin
                tx_cnt_d   = 4'd0;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_bit_end) begin
                tx_bit_d   = 3'd0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_bit_end) begin
                tx_shift_d = {1'b0, tx_shift[7:1]};
                if (tx_bit == 3'd7) tx_state_d = tx_m3 ? TX_NINTH : TX_STOP;
                else                tx_bit_d   = tx_bit + 3'd1;
            end
            TX_NINTH: if (tx_bit_end) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            TX_NINTH: txd_d = tx_nine_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_nine  <= 1'b0;
            tx_m3    <= 1'b0;
            txd      <= 1'b1;
            ti_set   <= 1'b0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
            tx_bit   <= tx_bit_d;
            tx_shift <= tx_shift_d;
            tx_nine  <= tx_nine_d;
            tx_m3    <= tx_m3_d;
            txd      <= txd_d;
            ti_set   <= (tx_state_d == TX_STOP) && (tx_state != TX_STOP);
        end
    end

    assign tx_busy = (tx_state != TX_IDLE);

    // ---------------- receiver ----------------
    logic [SYNC_STAGES-1:0] sync;
    logic rx_s, rx_prev, fall;

    // Idle-high line: synchroniser resets to 1 so reset release cannot fake a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rxd};
            rx_prev <= rx_s;
        end
    end
    assign rx_s = sync[SYNC_STAGES-1];
    assign fall = rx_prev & ~rx_s;

    rx_state_t  rx_state, rx_state_d;
    logic [3:0] rx_cnt, rx_cnt_d;
    logic [2:0] rx_bit, rx_bit_d;
    logic [7:0] rx_shift, rx_shift_d;
    logic       rx_m3, rx_m3_d, rx_b9, rx_b9_d, s7, s7_d, s8, s8_d;
    logic       vote, decide, rx_bit_end, accept, rb8_next;

    assign vote       = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign decide     = tick && (rx_cnt == 4'd9);
    assign rx_bit_end = tick && (rx_cnt == LAST_TICK);
    assign rb8_next   = rx_m3 ? rx_b9 : vote;

    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt;
        rx_bit_d   = rx_bit;
        rx_shift_d = rx_shift;
        rx_m3_d    = rx_m3;
        rx_b9_d    = rx_b9;
        s7_d       = s7;
        s8_d       = s8;
        accept     = 1'b0;
        if (rx_state != RX_IDLE && tick) begin
            rx_cnt_d = rx_cnt + 4'd1;
            if (rx_cnt == 4'd7) s7_d = rx_s;
            if (rx_cnt == 4'd8) s8_d = rx_s;
        end
        if (rx_state != RX_IDLE && !ren) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: if (fall && ren && mode_ok) begin
                    rx_cnt_d   = 4'd0;
                    rx_m3_d    = sm0;
                    rx_state_d = RX_START;
                end
                RX_START: begin
                    if (decide && vote) rx_state_d = RX_IDLE;
                    else if (rx_bit_end) begin
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (decide) rx_shift_d = {vote, rx_shift[7:1]};
                    if (rx_bit_end) begin
                        if (rx_bit == 3'd7) rx_state_d = rx_m3 ? RX_NINTH : RX_STOP;
                        else                rx_bit_d   = rx_bit + 3'd1;
                    end
                end
                RX_NINTH: begin
                    if (decide)     rx_b9_d    = vote;
                    if (rx_bit_end) rx_state_d = RX_STOP;
                end
                RX_STOP: if (decide) begin
                    rx_state_d = RX_IDLE;
                    accept     = !ri && (!sm2 || (rx_m3 ? rx_b9 : vote));
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_m3    <= 1'b0;
            rx_b9    <= 1'b0;
            s7       <= 1'b1;
            s8       <= 1'b1;
            rx_data  <= '0;
            rb8_val  <= 1'b0;
            ri_set   <= 1'b0;
            rb8_set  <= 1'b0;
        end else begin
            rx_state <= rx_state_d;
            rx_cnt   <= rx_cnt_d;
            rx_bit   <= rx_bit_d;
            rx_shift <= rx_shift_d;
            rx_m3    <= rx_m3_d;
            rx_b9    <= rx_b9_d;
            s7       <= s7_d;
            s8       <= s8_d;
            ri_set   <= accept;
            rb8_set  <= accept;
            if (accept) begin
                rx_data <= rx_shift;
                rb8_val <= rb8_next;
            end
        end
    end

    assign rx_busy = (rx_state != RX_IDLE);

endmodule
